// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, full-scan debounce and
// one-hot key code with a single-cycle strobe on each newly accepted key.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [2:0]  DEBOUNCE_SCANS = 3'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keypad_row,
  output logic [3:0]  keypad_col,
  output logic [15:0] key_code_o,
  output logic        key_valid,
  output logic        key_strobe
);

  logic [3:0]  row_s1, row_s;
  logic [15:0] div_cnt;
  logic [1:0]  col_idx;
  logic [15:0] raw, prev;
  logic [2:0]  stable_cnt;
  logic        eval_pending;

  logic        col_done;
  logic        scan_match;
  logic        accept;
  logic        one_hot;
  logic [15:0] new_code;
  logic [2:0]  next_cnt;

  assign keypad_col = ~(4'b0001 << col_idx);
  assign col_done   = (div_cnt == SCAN_DIV - 16'd1);
  assign scan_match = (raw == prev);
  // Accept once this evaluation brings the count to the threshold, or it is already saturated.
  assign accept     = scan_match && (stable_cnt >= DEBOUNCE_SCANS - 3'd1);
  assign one_hot    = (raw != 16'h0000) && ((raw & (raw - 16'd1)) == 16'h0000);
  assign new_code   = one_hot ? raw : 16'h0000;

  always_comb begin
    next_cnt = 3'd0;
    if (scan_match) begin
      next_cnt = (stable_cnt >= DEBOUNCE_SCANS) ? DEBOUNCE_SCANS : stable_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1       <= 4'hF;
      row_s        <= 4'hF;
      div_cnt      <= 16'd0;
      col_idx      <= 2'd0;
      raw          <= 16'h0000;
      prev         <= 16'h0000;
      stable_cnt   <= 3'd0;
      eval_pending <= 1'b0;
      key_code_o   <= 16'h0000;
      key_valid    <= 1'b0;
      key_strobe   <= 1'b0;
    end else begin
      row_s1       <= keypad_row;
      row_s        <= row_s1;
      key_strobe   <= 1'b0;
      eval_pending <= col_done && (col_idx == 2'd3);

      if (col_done) begin
        div_cnt                   <= 16'd0;
        raw[{col_idx, 2'b00} +: 4] <= ~row_s;
        col_idx                   <= col_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end

      // Evaluation runs alongside column 0 of the next scan; raw is not touched until
      // column 0 is sampled, SCAN_DIV cycles later.
      if (eval_pending) begin
        stable_cnt <= next_cnt;
        prev       <= raw;
        if (accept) begin
          key_code_o <= new_code;
          key_valid  <= |new_code;
          key_strobe <= (new_code != 16'h0000) && (new_code != key_code_o);
        end
      end
    end
  end

endmodule
